align_shifter: RTL and testbench

ALIGN_SHIFTER -- requirements
Module: align_shifter

---
 rtl/align_shifter.sv | 159 +++++++++++++++
 tb/tb_align_shifter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/align_shifter.sv
// ---------------------------------------------------------------------------
// align_shifter
//   Floating-point add pre-alignment stage. Accepts a pair of biased
//   exponents and 24-bit mantissas (hidden bit included), chooses the operand
//   with the larger exponent as the "big" one, and shifts the other mantissa
//   right by the exponent difference (clamped to 27). The result carries
//   guard/round/sticky bits in small_mant[2:0].
//
//   The shift is iterative: STEP bits per SHIFT cycle. STEP is 4 when
//   ALIGN_MULTI_BIT_STEP_EN is defined, otherwise 1. Results are
//   bit-identical in both builds; only the latency differs.
//
// Ports
//   clk         single clock, all state on rising edge
//   rst         synchronous active-high reset
//   in_valid    operand pair valid
//   in_ready    high only in IDLE
//   exp_a/b     biased exponents (EXP_W bits, EXP_W <= 32)
//   mant_a/b    24-bit mantissas including hidden bit
//   out_valid   aligned result valid (state DONE)
//   out_ready   downstream accepts result
//   big_mant    {larger-exponent mantissa, 3'b000}
//   small_mant  smaller-exponent mantissa, aligned, [2:0] = G,R,S
//   exp_common  larger exponent
//   swap        high when operand b has the larger exponent
// ---------------------------------------------------------------------------
module align_shifter #(
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic [23:0]      mant_a,
  input  logic [23:0]      mant_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [26:0]      big_mant,
  output logic [26:0]      small_mant,
  output logic [EXP_W-1:0] exp_common,
  output logic             swap
);

`ifdef ALIGN_MULTI_BIT_STEP_EN
  localparam logic [4:0] STEP = 5'd4;
`else
  localparam logic [4:0] STEP = 5'd1;
`endif

  localparam logic [4:0] R_MAX = 5'd27;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q;
  logic             in_ready_q, out_valid_q, swap_q;
  logic [26:0]      big_q, small_q;
  logic [EXP_W-1:0] exp_q;
  logic [4:0]       r_q;

  // ---------------- accept-side datapath ----------------
  logic             acc_swap;
  logic [EXP_W-1:0] acc_diff, acc_exp;
  logic [31:0]      acc_diff_w;
  logic [4:0]       acc_r;
  logic [26:0]      acc_big, acc_small;

  always_comb begin
    acc_swap   = (exp_b > exp_a);            // ties keep a as big
    acc_diff   = acc_swap ? (exp_b - exp_a) : (exp_a - exp_b);
    acc_exp    = acc_swap ? exp_b : exp_a;
    acc_diff_w = 32'(acc_diff);
    // Clamp before narrowing so large differences never wrap the 5-bit count.
    acc_r      = (acc_diff_w > 32'd27) ? R_MAX : acc_diff_w[4:0];
    acc_big    = acc_swap ? {mant_b, 3'b000} : {mant_a, 3'b000};
    acc_small  = acc_swap ? {mant_a, 3'b000} : {mant_b, 3'b000};
  end

  // ---------------- shift-side datapath ----------------
  logic [4:0]  shamt;
  logic [26:0] sticky_mask, shr;
  logic        sticky;
  logic [26:0] small_d;
  logic [4:0]  r_d;

  always_comb begin
    shamt       = (r_q < STEP) ? r_q : STEP;
    // Bits [shamt:0] of the old value: everything that falls off the bottom
    // plus the bit that lands in position 0 all feed the sticky bit.
    sticky_mask = ((27'd1 << shamt) << 1) - 27'd1;
    sticky      = |(small_q & sticky_mask);
    shr         = small_q >> shamt;
    small_d     = {shr[26:1], sticky};
    r_d         = r_q - shamt;
  end

  // ---------------- FSM and state ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      swap_q      <= 1'b0;
      big_q       <= '0;
      small_q     <= '0;
      exp_q       <= '0;
      r_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            swap_q     <= acc_swap;
            big_q      <= acc_big;
            small_q    <= acc_small;
            exp_q      <= acc_exp;
            r_q        <= acc_r;
            in_ready_q <= 1'b0;
            if (acc_r != 5'd0) begin
              state_q <= SHIFT;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          small_q <= small_d;
          r_q     <= r_d;
          if (r_d == 5'd0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // Handshake returns to IDLE; the earliest new accept is next edge.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign big_mant   = big_q;
  assign small_mant = small_q;
  assign exp_common = exp_q;
  assign swap       = swap_q;

endmodule

// File: tb/tb_align_shifter.sv
module tb_align_shifter;
`ifdef ALIGN_MULTI_BIT_STEP_EN
  localparam int STEP = 4;
`else
  localparam int STEP = 1;
`endif
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready, swap;
  logic [EW-1:0] exp_a, exp_b, exp_common;
  logic [23:0]   mant_a, mant_b;
  logic [26:0]   big_mant, small_mant;

  int n_cmp = 0;
  int n_bad = 0;

  align_shifter #(.EXP_W(EW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .exp_a(exp_a), .exp_b(exp_b), .mant_a(mant_a), .mant_b(mant_b),
    .out_valid(out_valid), .out_ready(out_ready), .big_mant(big_mant),
    .small_mant(small_mant), .exp_common(exp_common), .swap(swap)
  );

  always #5 clk = ~clk;

  // Reference: one-shot alignment computed from the exponent difference.
  task automatic model(input logic [EW-1:0] ea, eb, input logic [23:0] ma, mb,
                       output logic [26:0] bm, sm, output logic [EW-1:0] ec,
                       output logic sw, output int lat);
    int d;
    logic [26:0] v, mask;
    sw = (eb > ea);
    d  = sw ? int'(eb) - int'(ea) : int'(ea) - int'(eb);
    ec = sw ? eb : ea;
    bm = sw ? {mb, 3'b000} : {ma, 3'b000};
    v  = sw ? {ma, 3'b000} : {mb, 3'b000};
    if (d > 27) d = 27;
    if (d == 27) sm = {26'd0, (v != 27'd0)};
    else begin
      sm   = v >> d;
      mask = (27'd1 << d) - 27'd1;
      if ((v & mask) != 27'd0) sm[0] = 1'b1;
    end
    lat = 1 + (d + STEP - 1) / STEP;
  endtask

  // Drives one accept and measures edges (accept edge counted as 1) until
  // out_valid; leaves the DUT in DONE. lat = 99 on timeout.
  task automatic do_txn(input logic [EW-1:0] ea, eb, input logic [23:0] ma, mb,
                        output int lat);
    int w = 0;
    while (!in_ready && w < 64) begin @(posedge clk); #1; w++; end
    exp_a = ea; exp_b = eb; mant_a = ma; mant_b = mb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin @(posedge clk); #1; lat++; end
    if (!out_valid) lat = 99;
  endtask

  task automatic finish_txn();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    exp_a = 8'h90; exp_b = 8'h10; mant_a = 24'hFFFFFF; mant_b = 24'hFFFFFF;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, swap} !== 3'b100 || big_mant !== 27'd0 ||
        small_mant !== 27'd0 || exp_common !== 8'd0) begin
      n_bad++;
      $display("FAIL reset: rdy=%b vld=%b sw=%b big=%h small=%h exp=%h want rdy=1 others 0",
               in_ready, out_valid, swap, big_mant, small_mant, exp_common);
    end
  endtask

  task automatic test_directed();
    logic [EW-1:0] ea[4] = '{8'h85, 8'h85, 8'h50, 8'h42};
    logic [EW-1:0] eb[4] = '{8'h80, 8'h85, 8'h78, 8'h42};
    logic [23:0]   ma[4] = '{24'hC00000, 24'hC00000, 24'h800000, 24'h9ABCDE};
    logic [23:0]   mb[4] = '{24'h800000, 24'h800001, 24'hA00000, 24'hF12345};
    logic [26:0]   want_sm[4] = '{27'h0200000, 27'h4000008, 27'h0000001,
                                  {24'hF12345, 3'b000}};
    for (int i = 0; i < 4; i++) begin
      logic [26:0] bm, sm; logic [EW-1:0] ec; logic sw; int lat, got;
      model(ea[i], eb[i], ma[i], mb[i], bm, sm, ec, sw, lat);
      do_txn(ea[i], eb[i], ma[i], mb[i], got);
      n_cmp++;
      if (small_mant !== want_sm[i] || sm !== want_sm[i]) begin
        n_bad++;
        $display("FAIL directed%0d small: got %h model %h want %h", i, small_mant, sm, want_sm[i]);
      end
      n_cmp++;
      if (big_mant !== bm || exp_common !== ec || swap !== sw) begin
        n_bad++;
        $display("FAIL directed%0d big/exp/swap: got %h/%h/%b want %h/%h/%b",
                 i, big_mant, exp_common, swap, bm, ec, sw);
      end
      n_cmp++;
      if (got != lat) begin
        n_bad++;
        $display("FAIL directed%0d latency: got %0d want %0d", i, got, lat);
      end
      finish_txn();
    end
    // Same exponents as the first case with a low mantissa bit: sticky set.
    begin
      int got;
      do_txn(8'h85, 8'h80, 24'hC00000, 24'h800001, got);
      n_cmp++;
      if (small_mant !== 27'h0200001) begin
        n_bad++;
        $display("FAIL sticky: got %h want 0200001", small_mant);
      end
      finish_txn();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      logic [EW-1:0] ea, eb; logic [23:0] ma, mb;
      logic [26:0] bm, sm; logic [EW-1:0] ec; logic sw; int lat, got, hold;
      ea = EW'($urandom);
      eb = ($urandom_range(0, 3) == 0) ? EW'($urandom) : EW'(ea + EW'($urandom_range(0, 60)) - EW'(30));
      ma = ($urandom_range(0, 9) == 0) ? 24'd0 : (24'h800000 | 24'($urandom));
      mb = ($urandom_range(0, 9) == 0) ? 24'd0 : (24'h800000 | 24'($urandom));
      model(ea, eb, ma, mb, bm, sm, ec, sw, lat);
      do_txn(ea, eb, ma, mb, got);
      hold = $urandom_range(0, 3);
      repeat (hold) begin @(posedge clk); #1; end
      n_cmp++;
      if (got != lat || big_mant !== bm || small_mant !== sm ||
          exp_common !== ec || swap !== sw || out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL random%0d ea=%h eb=%h ma=%h mb=%h: got lat%0d %h %h %h %b v%b want lat%0d %h %h %h %b",
                 i, ea, eb, ma, mb, got, big_mant, small_mant, exp_common, swap, out_valid,
                 lat, bm, sm, ec, sw);
      end
      finish_txn();
    end
  endtask

  task automatic test_backpressure();
    logic [26:0] bm, sm; logic [EW-1:0] ec; logic sw; int lat, got;
    model(8'h70, 8'h73, 24'hABCDEF, 24'h876543, bm, sm, ec, sw, lat);
    do_txn(8'h70, 8'h73, 24'hABCDEF, 24'h876543, got);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      exp_a = EW'($urandom); exp_b = EW'($urandom);
      mant_a = 24'($urandom); mant_b = 24'($urandom);
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || big_mant !== bm ||
          small_mant !== sm || exp_common !== ec || swap !== sw) begin
        n_bad++;
        $display("FAIL hold%0d: v=%b r=%b %h %h %h %b want v=1 r=0 %h %h %h %b",
                 c, out_valid, in_ready, big_mant, small_mant, exp_common, swap, bm, sm, ec, sw);
      end
    end
    // in_valid still high on the handshake edge: must not be accepted there.
    exp_a = 8'h20; exp_b = 8'h20; mant_a = 24'h800000; mant_b = 24'hC00000;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL handshake_gap: rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
    @(posedge clk); #1;   // accept happens here (equal exponents -> DONE)
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || small_mant !== {24'hC00000, 3'b000}) begin
      n_bad++;
      $display("FAIL back_to_back: rdy=%b vld=%b small=%h want 0/1/%h",
               in_ready, out_valid, small_mant, {24'hC00000, 3'b000});
    end
    finish_txn();
  endtask

  task automatic test_midreset();
    logic [26:0] bm, sm; logic [EW-1:0] ec; logic sw; int lat, got;
    exp_a = 8'h40; exp_b = 8'h54; mant_a = 24'hFFFFFF; mant_b = 24'h812345;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, swap} !== 3'b100 || big_mant !== 27'd0 ||
        small_mant !== 27'd0 || exp_common !== 8'd0) begin
      n_bad++;
      $display("FAIL midreset: rdy=%b vld=%b sw=%b %h %h %h want 1/0/0 zeros",
               in_ready, out_valid, swap, big_mant, small_mant, exp_common);
    end
    model(8'h66, 8'h60, 24'h800000, 24'hFFFFFF, bm, sm, ec, sw, lat);
    do_txn(8'h66, 8'h60, 24'h800000, 24'hFFFFFF, got);
    n_cmp++;
    if (got != lat || big_mant !== bm || small_mant !== sm || exp_common !== ec || swap !== sw) begin
      n_bad++;
      $display("FAIL after_reset: lat%0d %h %h %h %b want lat%0d %h %h %h %b",
               got, big_mant, small_mant, exp_common, swap, lat, bm, sm, ec, sw);
    end
    finish_txn();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
